// File: rtl/ucsbece154b_hazard_ctrl.sv
// Hazard and pipeline-control unit for the 5-stage core: tracks E/M/W control
// fields and derives stall, flush, redirect and forwarding controls.
module ucsbece154b_hazard_ctrl #(
    parameter int REG_AW  = 5,
    parameter int MUL_LAT = 3,
    parameter int CNT_W   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ValidD_i,
    input  logic              RegWriteD_i,
    input  logic              LoadD_i,
    input  logic              MulD_i,
    input  logic              BranchD_i,
    input  logic              JumpD_i,
    input  logic [REG_AW-1:0] RdD_i,
    input  logic [REG_AW-1:0] Rs1D_i,
    input  logic [REG_AW-1:0] Rs2D_i,
    input  logic [REG_AW-1:0] Rs1E_i,
    input  logic [REG_AW-1:0] Rs2E_i,
    input  logic              ZeroE_i,
    output logic              StallF_o,
    output logic              StallD_o,
    output logic              StallE_o,
    output logic              FlushD_o,
    output logic              FlushE_o,
    output logic              PCSrcE_o,
    output logic [1:0]        ForwardAE_o,
    output logic [1:0]        ForwardBE_o,
    output logic [REG_AW-1:0] RdE_o,
    output logic [REG_AW-1:0] RdM_o,
    output logic [REG_AW-1:0] RdW_o,
    output logic              RegWriteW_o,
    output logic              MulBusy_o
);

    typedef struct packed {
        logic              valid;
        logic              regwrite;
        logic              load;
        logic              mul;
        logic              branch;
        logic              jump;
        logic [REG_AW-1:0] rd;
    } stage_e_t;

    // Past E only the write-back identity matters to any consumer.
    typedef struct packed {
        logic              valid;
        logic              regwrite;
        logic [REG_AW-1:0] rd;
    } stage_wb_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT - 1);

    stage_e_t         e_q, e_d;
    stage_wb_t        m_q, m_d;
    stage_wb_t        w_q, w_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic mul_busy;
    logic lw_stall;
    logic pcsrc;
    logic flush_e;

    assign mul_busy = e_q.valid & e_q.mul & (cnt_q != CNT_LAST);
    assign lw_stall = e_q.valid & e_q.load & e_q.regwrite & (e_q.rd != '0)
                    & ((Rs1D_i == e_q.rd) | (Rs2D_i == e_q.rd));
    assign pcsrc    = e_q.valid & (e_q.jump | (e_q.branch & ZeroE_i));
    assign flush_e  = pcsrc | (lw_stall & ~mul_busy);

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                           input stage_wb_t m,
                                           input stage_wb_t w);
        logic [1:0] sel;
        sel = 2'b00;
        if (m.valid && m.regwrite && (m.rd != '0) && (rs == m.rd)) begin
            sel = 2'b10;
        end else if (w.valid && w.regwrite && (w.rd != '0) && (rs == w.rd)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    always_comb begin
        e_d   = e_q;
        m_d   = '0;
        w_d   = m_q;
        cnt_d = '0;
        if (flush_e) begin
            e_d = '0;
        end else if (!mul_busy) begin
            e_d.valid    = ValidD_i;
            e_d.regwrite = RegWriteD_i;
            e_d.load     = LoadD_i;
            e_d.mul      = MulD_i;
            e_d.branch   = BranchD_i;
            e_d.jump     = JumpD_i;
            e_d.rd       = RdD_i;
        end
        if (mul_busy) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            m_d.valid    = e_q.valid;
            m_d.regwrite = e_q.regwrite;
            m_d.rd       = e_q.rd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q   <= '0;
            m_q   <= '0;
            w_q   <= '0;
            cnt_q <= '0;
        end else begin
            e_q   <= e_d;
            m_q   <= m_d;
            w_q   <= w_d;
            cnt_q <= cnt_d;
        end
    end

    assign StallF_o    = lw_stall | mul_busy;
    assign StallD_o    = lw_stall | mul_busy;
    assign StallE_o    = mul_busy;
    assign FlushD_o    = pcsrc;
    assign FlushE_o    = flush_e;
    assign PCSrcE_o    = pcsrc;
    assign MulBusy_o   = mul_busy;
    assign ForwardAE_o = fwd_sel(Rs1E_i, m_q, w_q);
    assign ForwardBE_o = fwd_sel(Rs2E_i, m_q, w_q);
    assign RdE_o       = e_q.rd;
    assign RdM_o       = m_q.rd;
    assign RdW_o       = w_q.rd;
    assign RegWriteW_o = w_q.valid & w_q.regwrite;

endmodule

// File: tb/tb_ucsbece154b_hazard_ctrl.sv
// Self-checking bench for ucsbece154b_hazard_ctrl: instruction-level pipeline
// model compared every cycle, plus hand-computed checks per scenario.
module tb_ucsbece154b_hazard_ctrl;
    localparam int REG_AW  = 5;
    localparam int MUL_LAT = 3;
    localparam int CNT_W   = 2;

    typedef struct packed {
        logic v, rw, ld, mu, br, jp;
        logic [4:0] rd, rs1, rs2;
    } ins_t;
    localparam ins_t NOP = '0;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ValidD_i, RegWriteD_i, LoadD_i, MulD_i, BranchD_i, JumpD_i, ZeroE_i;
    logic [REG_AW-1:0] RdD_i, Rs1D_i, Rs2D_i, Rs1E_i, Rs2E_i;
    logic StallF_o, StallD_o, StallE_o, FlushD_o, FlushE_o, PCSrcE_o;
    logic [1:0] ForwardAE_o, ForwardBE_o;
    logic [REG_AW-1:0] RdE_o, RdM_o, RdW_o;
    logic RegWriteW_o, MulBusy_o;

    int total = 0;
    int bad = 0;

    ucsbece154b_hazard_ctrl #(.REG_AW(REG_AW), .MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .ValidD_i(ValidD_i), .RegWriteD_i(RegWriteD_i), .LoadD_i(LoadD_i),
        .MulD_i(MulD_i), .BranchD_i(BranchD_i), .JumpD_i(JumpD_i),
        .RdD_i(RdD_i), .Rs1D_i(Rs1D_i), .Rs2D_i(Rs2D_i),
        .Rs1E_i(Rs1E_i), .Rs2E_i(Rs2E_i), .ZeroE_i(ZeroE_i),
        .StallF_o(StallF_o), .StallD_o(StallD_o), .StallE_o(StallE_o),
        .FlushD_o(FlushD_o), .FlushE_o(FlushE_o), .PCSrcE_o(PCSrcE_o),
        .ForwardAE_o(ForwardAE_o), .ForwardBE_o(ForwardBE_o),
        .RdE_o(RdE_o), .RdM_o(RdM_o), .RdW_o(RdW_o),
        .RegWriteW_o(RegWriteW_o), .MulBusy_o(MulBusy_o)
    );

    always #5 clk = ~clk;

    // Instruction-level model: which instruction sits in E/M/W and how long
    // the E instruction has been there.
    ins_t me = NOP, mm = NOP, mw = NOP;
    int   age = 0;
    bit   model_ok = 0;
    bit   last_stall_d = 0, last_flush_d = 0, last_rst = 0;

    assign Rs1E_i = me.rs1;
    assign Rs2E_i = me.rs2;

    function automatic bit exp_busy();
        return me.v && me.mu && (age < MUL_LAT - 1);
    endfunction

    function automatic bit exp_lw();
        return me.v && me.ld && me.rw && (me.rd != 0) &&
               ((Rs1D_i == me.rd) || (Rs2D_i == me.rd));
    endfunction

    function automatic bit exp_pc();
        return me.v && (me.jp || (me.br && ZeroE_i));
    endfunction

    function automatic int exp_fwd(input logic [4:0] rs);
        if (mm.v && mm.rw && mm.rd != 0 && rs == mm.rd) return 2;
        if (mw.v && mw.rw && mw.rd != 0 && rs == mw.rd) return 1;
        return 0;
    endfunction

    always @(posedge clk) begin
        bit busy, lw, pc;
        ins_t din;
        busy = exp_busy();
        lw   = exp_lw();
        pc   = exp_pc();
        din  = '{ValidD_i, RegWriteD_i, LoadD_i, MulD_i, BranchD_i, JumpD_i,
                 RdD_i, Rs1D_i, Rs2D_i};
        last_stall_d <= lw || busy;
        last_flush_d <= pc;
        last_rst     <= reset;
        if (reset) begin
            me <= NOP; mm <= NOP; mw <= NOP; age <= 0;
            model_ok <= 1'b1;
        end else begin
            mw <= mm;
            mm <= busy ? NOP : me;
            if (pc || (lw && !busy)) begin
                me <= NOP; age <= 0;
            end else if (busy) begin
                age <= age + 1;
            end else begin
                me <= din; age <= 0;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (model_ok) begin
            bit busy, lw, pc;
            busy = exp_busy();
            lw   = exp_lw();
            pc   = exp_pc();
            chk("m_StallF", int'(StallF_o), int'(lw || busy));
            chk("m_StallD", int'(StallD_o), int'(lw || busy));
            chk("m_StallE", int'(StallE_o), int'(busy));
            chk("m_MulBusy", int'(MulBusy_o), int'(busy));
            chk("m_PCSrcE", int'(PCSrcE_o), int'(pc));
            chk("m_FlushD", int'(FlushD_o), int'(pc));
            chk("m_FlushE", int'(FlushE_o), int'(pc || (lw && !busy)));
            chk("m_FwdA", int'(ForwardAE_o), exp_fwd(me.rs1));
            chk("m_FwdB", int'(ForwardBE_o), exp_fwd(me.rs2));
            chk("m_RegWriteW", int'(RegWriteW_o), int'(mw.v && mw.rw));
            if (me.v) chk("m_RdE", int'(RdE_o), int'(me.rd));
            if (mm.v) chk("m_RdM", int'(RdM_o), int'(mm.rd));
            if (mw.v) chk("m_RdW", int'(RdW_o), int'(mw.rd));
        end
    end

    // Fetch/decode emulation: D holds on stall, takes a bubble on redirect
    // (dropping the instruction that was in F), otherwise takes the next one.
    ins_t dreg = NOP;
    ins_t prog[$];

    function automatic ins_t mk(input bit rw, ld, mu, br, jp,
                                input int rd, rs1, rs2);
        ins_t i;
        i = '{1'b1, rw, ld, mu, br, jp, 5'(rd), 5'(rs1), 5'(rs2)};
        return i;
    endfunction

    task automatic drive(input bit zero);
        ValidD_i = dreg.v; RegWriteD_i = dreg.rw; LoadD_i = dreg.ld;
        MulD_i = dreg.mu; BranchD_i = dreg.br; JumpD_i = dreg.jp;
        RdD_i = dreg.rd; Rs1D_i = dreg.rs1; Rs2D_i = dreg.rs2;
        ZeroE_i = zero;
    endtask

    task automatic step(input bit zero, input bit rst);
        @(posedge clk);
        #1;
        if (last_rst) begin
            dreg = NOP;
        end else if (!last_stall_d) begin
            if (last_flush_d) begin
                dreg = NOP;
                if (prog.size() > 0) void'(prog.pop_front());
            end else begin
                dreg = (prog.size() > 0) ? prog.pop_front() : NOP;
            end
        end
        reset = rst;
        drive(zero);
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    initial begin
        // Reset with random inputs for two cycles.
        reset = 1'b1;
        {ValidD_i, RegWriteD_i, LoadD_i, MulD_i, BranchD_i, JumpD_i, ZeroE_i} = 7'($urandom);
        {RdD_i, Rs1D_i, Rs2D_i} = 15'($urandom);
        @(posedge clk); #1;
        {ValidD_i, RegWriteD_i, LoadD_i, MulD_i, BranchD_i, JumpD_i, ZeroE_i} = 7'($urandom);
        {RdD_i, Rs1D_i, Rs2D_i} = 15'($urandom);
        @(negedge clk); #1;
        chk("rst_StallF", int'(StallF_o), 0);
        chk("rst_StallD", int'(StallD_o), 0);
        chk("rst_StallE", int'(StallE_o), 0);
        chk("rst_FlushD", int'(FlushD_o), 0);
        chk("rst_FlushE", int'(FlushE_o), 0);
        chk("rst_PCSrcE", int'(PCSrcE_o), 0);
        chk("rst_MulBusy", int'(MulBusy_o), 0);
        chk("rst_RegWriteW", int'(RegWriteW_o), 0);
        chk("rst_FwdA", int'(ForwardAE_o), 0);
        chk("rst_FwdB", int'(ForwardBE_o), 0);
        chk("rst_Rd", int'({RdE_o, RdM_o, RdW_o}), 0);
        step(1'b0, 1'b0);

        // Back-to-back ALU forwarding.
        prog.push_back(mk(1, 0, 0, 0, 0, 5, 1, 2));
        prog.push_back(mk(1, 0, 0, 0, 0, 9, 5, 3));
        prog.push_back(mk(1, 0, 0, 0, 0, 10, 4, 5));
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("alu_FwdA_M", int'(ForwardAE_o), 2);
        chk("alu_RdM", int'(RdM_o), 5);
        step(1'b0, 1'b0);
        chk("alu_FwdB_W", int'(ForwardBE_o), 1);
        chk("alu_FwdA_none", int'(ForwardAE_o), 0);
        chk("alu_RegWriteW", int'(RegWriteW_o), 1);
        idle(4);

        // Load-use: one bubble, then forward from W.
        prog.push_back(mk(1, 1, 0, 0, 0, 6, 1, 0));
        prog.push_back(mk(1, 0, 0, 0, 0, 7, 6, 1));
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("lu_StallF", int'(StallF_o), 1);
        chk("lu_StallD", int'(StallD_o), 1);
        chk("lu_FlushE", int'(FlushE_o), 1);
        chk("lu_StallE", int'(StallE_o), 0);
        step(1'b0, 1'b0);
        chk("lu_StallF_off", int'(StallF_o), 0);
        step(1'b0, 1'b0);
        chk("lu_FwdA_W", int'(ForwardAE_o), 1);
        chk("lu_RdW", int'(RdW_o), 6);
        idle(4);

        // Multi-cycle op, MUL_LAT = 3.
        prog.push_back(mk(1, 0, 1, 0, 0, 8, 1, 2));
        prog.push_back(mk(1, 0, 0, 0, 0, 11, 8, 2));
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("mul_StallE_1", int'(StallE_o), 1);
        chk("mul_StallF_1", int'(StallF_o), 1);
        step(1'b0, 1'b0);
        chk("mul_StallE_2", int'(StallE_o), 1);
        chk("mul_RegWriteW_bub", int'(RegWriteW_o), 0);
        step(1'b0, 1'b0);
        chk("mul_StallE_3", int'(StallE_o), 0);
        chk("mul_Busy_3", int'(MulBusy_o), 0);
        step(1'b0, 1'b0);
        chk("mul_FwdA_M", int'(ForwardAE_o), 2);
        chk("mul_RdM", int'(RdM_o), 8);
        idle(4);

        // Not-taken branch, then taken branch with lw/consumer behind it.
        prog.push_back(mk(0, 0, 0, 1, 0, 0, 1, 2));
        prog.push_back(mk(0, 0, 0, 1, 0, 0, 3, 4));
        prog.push_back(mk(1, 1, 0, 0, 0, 6, 1, 0));
        prog.push_back(mk(1, 0, 0, 0, 0, 7, 6, 1));
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("br_nt_PCSrc", int'(PCSrcE_o), 0);
        step(1'b1, 1'b0);
        chk("br_PCSrc", int'(PCSrcE_o), 1);
        chk("br_FlushD", int'(FlushD_o), 1);
        chk("br_FlushE", int'(FlushE_o), 1);
        chk("br_StallF", int'(StallF_o), 0);
        step(1'b1, 1'b0);
        chk("br_PCSrc_off", int'(PCSrcE_o), 0);
        chk("br_StallF_after", int'(StallF_o), 0);
        idle(4);

        // Reset in the second stall cycle of a mul.
        prog.push_back(mk(1, 0, 1, 0, 0, 8, 1, 2));
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("rm_StallE_1", int'(StallE_o), 1);
        step(1'b0, 1'b1);
        chk("rm_StallE_2", int'(StallE_o), 1);
        step(1'b0, 1'b0);
        chk("rm_StallE_after", int'(StallE_o), 0);
        chk("rm_Busy_after", int'(MulBusy_o), 0);
        chk("rm_StallF_after", int'(StallF_o), 0);

        // Writes to x0 never forward.
        prog.push_back(mk(1, 0, 0, 0, 0, 0, 1, 2));
        prog.push_back(mk(1, 0, 0, 0, 0, 12, 0, 0));
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("x0_FwdA_M", int'(ForwardAE_o), 0);
        chk("x0_FwdB_M", int'(ForwardBE_o), 0);
        step(1'b0, 1'b0);
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end
endmodule
